// File: rtl/early_exit_monitor_pkg.sv
// Shared definitions for the early-exit monitor: default widths, on/off levels
// and the frame-control state encoding.
package early_exit_monitor_pkg;

   localparam int BIT_SOFTMAX = 16;
   localparam int BIT_CLASS   = 4;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/exit_streak_counter.sv
// Tracks how many consecutive beats the same class has won at or above the
// threshold; exposes the post-beat streak combinationally for exit decisions.
module exit_streak_counter
   import early_exit_monitor_pkg::*;
#(
   parameter int BIT_Z    = BIT_SOFTMAX,
   parameter int BIT_O    = BIT_CLASS,
   parameter int STABLE_N = 3,
   parameter int BIT_S    = $clog2(STABLE_N + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_beat,
   input  logic [BIT_Z-1:0] i_z,
   input  logic [BIT_O-1:0] i_index,
   input  logic [BIT_Z-1:0] i_thr,
   output logic [BIT_S-1:0] o_streakNext,
   output logic             o_hit
);

   logic [BIT_S-1:0] r_streak;
   logic [BIT_O-1:0] r_prevIdx;
   logic             w_qualify;

   // The streak is held at STABLE_N rather than incremented, so it can never wrap.
   always_comb begin
      w_qualify    = ($signed(i_z) >= $signed(i_thr));
      o_streakNext = '0;
      if (w_qualify) begin
         if ((r_streak != '0) && (i_index == r_prevIdx)) begin
            o_streakNext = (r_streak == BIT_S'(STABLE_N)) ? r_streak : (r_streak + BIT_S'(1));
         end else begin
            o_streakNext = BIT_S'(1);
         end
      end
      o_hit = (o_streakNext == BIT_S'(STABLE_N));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_streak  <= '0;
         r_prevIdx <= '0;
      end else if (i_clear) begin
         r_streak  <= '0;
         r_prevIdx <= '0;
      end else if (i_beat) begin
         r_streak  <= o_streakNext;
         r_prevIdx <= i_index;
      end
   end

endmodule

// File: rtl/early_exit_monitor.sv
// Watches the per-cycle top-1 output of the softmax stage and decides a class
// either early (stable confident streak) or at frame end (best score seen).
module early_exit_monitor
   import early_exit_monitor_pkg::*;
#(
   parameter int BIT_Z     = BIT_SOFTMAX,
   parameter int BIT_O     = BIT_CLASS,
   parameter int STABLE_N  = 3,
   parameter int FRAME_LEN = 128,
   parameter int BIT_C     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             valid_in,
   input  logic [BIT_Z-1:0] z,
   input  logic [BIT_O-1:0] index,
   input  logic [BIT_Z-1:0] threshold,
   output logic             busy,
   output logic             result_valid,
   output logic [BIT_O-1:0] result_class,
   output logic [BIT_Z-1:0] result_conf,
   output logic             early,
   output logic [BIT_C-1:0] beats_used
);

   localparam int               BIT_S    = $clog2(STABLE_N + 1);
   localparam logic [BIT_Z-1:0] MOST_NEG = {1'b1, {(BIT_Z-1){1'b0}}};

   state_t           r_state;
   state_t           w_stateNext;
   logic [BIT_C-1:0] r_beats;
   logic [BIT_Z-1:0] r_thr;
   logic [BIT_Z-1:0] r_bestZ;
   logic [BIT_O-1:0] r_bestIdx;
   logic [BIT_O-1:0] r_resClass;
   logic [BIT_Z-1:0] r_resConf;
   logic             r_early;
   logic [BIT_C-1:0] r_beatsUsed;

   logic             w_beat;
   logic [BIT_C-1:0] w_beatsNext;
   logic             w_better;
   logic [BIT_Z-1:0] w_bestZNext;
   logic [BIT_O-1:0] w_bestIdxNext;
   logic [BIT_S-1:0] w_streakNext;
   logic             w_streakHit;
   logic             w_frameEnd;
   logic             w_term;

   // A beat coinciding with start belongs to neither the old nor the new frame.
   assign w_beat        = (r_state == TRACK) && valid_in && !start;
   assign w_beatsNext   = r_beats + BIT_C'(1);
   assign w_better      = ($signed(z) > $signed(r_bestZ));
   assign w_bestZNext   = w_better ? z : r_bestZ;
   assign w_bestIdxNext = w_better ? index : r_bestIdx;
   assign w_frameEnd    = w_beat && (w_beatsNext == BIT_C'(FRAME_LEN));
   assign w_term        = (w_beat && w_streakHit) || w_frameEnd;

   exit_streak_counter #(
      .BIT_Z    (BIT_Z),
      .BIT_O    (BIT_O),
      .STABLE_N (STABLE_N),
      .BIT_S    (BIT_S)
   ) u_streak (
      .clock        (clock),
      .reset        (reset),
      .i_clear      (start),
      .i_beat       (w_beat),
      .i_z          (z),
      .i_index      (index),
      .i_thr        (r_thr),
      .o_streakNext (w_streakNext),
      .o_hit        (w_streakHit)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Start wins in every state, so a restart in TRACK discards the open frame.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (start) w_stateNext = TRACK;
         TRACK:   begin
                     if (start)       w_stateNext = TRACK;
                     else if (w_term) w_stateNext = DONE;
                  end
         DONE:    w_stateNext = start ? TRACK : IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_beats     <= '0;
         r_thr       <= '0;
         r_bestZ     <= '0;
         r_bestIdx   <= '0;
         r_resClass  <= '0;
         r_resConf   <= '0;
         r_early     <= OFF;
         r_beatsUsed <= '0;
      end else begin
         if (start) begin
            r_beats   <= '0;
            r_thr     <= threshold;
            r_bestZ   <= MOST_NEG;
            r_bestIdx <= '0;
         end else if (w_beat) begin
            r_beats   <= w_beatsNext;
            r_bestZ   <= w_bestZNext;
            r_bestIdx <= w_bestIdxNext;
         end
         // Early exit is checked first so a streak completing on the last beat still reports early.
         if (w_term) begin
            r_beatsUsed <= w_beatsNext;
            if (w_streakHit) begin
               r_resClass <= index;
               r_resConf  <= z;
               r_early    <= ON;
            end else begin
               r_resClass <= w_bestIdxNext;
               r_resConf  <= w_bestZNext;
               r_early    <= OFF;
            end
         end
      end
   end

   assign busy         = (r_state == TRACK);
   assign result_valid = (r_state == DONE);
   assign result_class = r_resClass;
   assign result_conf  = r_resConf;
   assign early        = r_early;
   assign beats_used   = r_beatsUsed;

endmodule

// File: tb/tb_early_exit_monitor.sv
// Self-checking bench: directed frames plus random traffic, compared every cycle
// against a frame-history model of the exit rules.
module tb_early_exit_monitor;

   localparam int BIT_Z     = 16;
   localparam int BIT_O     = 4;
   localparam int STABLE_N  = 3;
   localparam int FRAME_LEN = 8;
   localparam int BIT_C     = $clog2(FRAME_LEN + 1);

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             valid_in = 1'b0;
   logic [BIT_Z-1:0] z = '0;
   logic [BIT_O-1:0] index = '0;
   logic [BIT_Z-1:0] threshold = '0;
   logic             busy;
   logic             result_valid;
   logic [BIT_O-1:0] result_class;
   logic [BIT_Z-1:0] result_conf;
   logic             early;
   logic [BIT_C-1:0] beats_used;

   int checks   = 0;
   int failures = 0;

   // Reference model: the open frame's beat history, plus held result values.
   int zq[$];
   int iq[$];
   bit mOpen = 0;
   int mThr = 0;
   bit eValid = 0;
   int eClass = 0;
   int eConf = 0;
   int eEarly = 0;
   int eBeats = 0;

   early_exit_monitor #(
      .BIT_Z     (BIT_Z),
      .BIT_O     (BIT_O),
      .STABLE_N  (STABLE_N),
      .FRAME_LEN (FRAME_LEN),
      .BIT_C     (BIT_C)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .valid_in     (valid_in),
      .z            (z),
      .index        (index),
      .threshold    (threshold),
      .busy         (busy),
      .result_valid (result_valid),
      .result_class (result_class),
      .result_conf  (result_conf),
      .early        (early),
      .beats_used   (beats_used)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mOpen  = 0;
      zq.delete();
      iq.delete();
      mThr   = 0;
      eValid = 0;
      eClass = 0;
      eConf  = 0;
      eEarly = 0;
      eBeats = 0;
   endtask

   // Apply the exit rules to the frame history as seen at one clock edge.
   task automatic modelEdge(input bit st, input bit v, input int zs, input int ii);
      int run;
      int bz;
      int bi;
      eValid = 0;
      if (st) begin
         mOpen = 1;
         zq.delete();
         iq.delete();
         mThr = $signed(threshold);
      end else if (mOpen && v) begin
         zq.push_back(zs);
         iq.push_back(ii);
         run = 0;
         for (int k = zq.size() - 1; k >= 0; k--) begin
            if (zq[k] >= mThr && iq[k] == ii) run++;
            else break;
         end
         if (run >= STABLE_N) begin
            eValid = 1; eClass = ii; eConf = zs; eEarly = 1; eBeats = zq.size();
            mOpen = 0;
         end else if (zq.size() == FRAME_LEN) begin
            bz = -(1 << (BIT_Z - 1));
            bi = 0;
            foreach (zq[k]) begin
               if (zq[k] > bz) begin
                  bz = zq[k];
                  bi = iq[k];
               end
            end
            eValid = 1; eClass = bi; eConf = bz; eEarly = 0; eBeats = zq.size();
            mOpen = 0;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("busy", int'(busy), int'(mOpen));
      checkOutput("result_valid", int'(result_valid), int'(eValid));
      checkOutput("result_class", int'(result_class), eClass);
      checkOutput("result_conf", int'($signed(result_conf)), eConf);
      checkOutput("early", int'(early), eEarly);
      checkOutput("beats_used", int'(beats_used), eBeats);
   endtask

   task automatic applyStimulus(input bit st, input bit v, input int zs, input int ii);
      @(negedge clock);
      start    = st;
      valid_in = v;
      z        = BIT_Z'(zs);
      index    = BIT_O'(ii);
      @(posedge clock);
      modelEdge(st, v, $signed(z), int'(index));
      #1;
      compareAll();
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      modelReset();
      compareAll();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
   endtask

   initial begin
      int zTbl[12] = '{-32768, -50, -20, -10, -5, 0, 50, 99, 100, 101, 200, 32767};
      int thrTbl[3] = '{-10, 0, 100};
      int f1z[8] = '{10, 20, 30, 90, 40, 50, 60, 70};
      int f3z[6] = '{120, 120, 80, 120, 120, 130};
      bit st;

      #1;
      compareAll();
      @(negedge clock);
      reset = 1'b0;

      threshold = 16'd100;
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 120, 2);
      checkOutput("case1 valid", int'(result_valid), 1);
      checkOutput("case1 class", int'(result_class), 2);
      checkOutput("case1 conf", int'($signed(result_conf)), 120);
      checkOutput("case1 early", int'(early), 1);
      checkOutput("case1 beats", int'(beats_used), 3);
      checkOutput("case1 busy", int'(busy), 0);
      idle(2);

      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, f1z[i], (i % 2 == 0) ? 1 : 5);
      checkOutput("case2 class", int'(result_class), 5);
      checkOutput("case2 conf", int'($signed(result_conf)), 90);
      checkOutput("case2 early", int'(early), 0);
      checkOutput("case2 beats", int'(beats_used), 8);
      idle(1);

      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, f3z[i], 3);
      idle(1);

      applyStimulus(1, 1, 200, 4);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 200, 4);
      idle(1);

      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 150, 6);
      applyStimulus(0, 1, 150, 6);
      applyReset();
      idle(2);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 150, 6);
      idle(1);

      threshold = -16'sd10;
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, -5, 7);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, -20, 7);
      idle(1);

      for (int c = 0; c < 3000; c++) begin
         threshold = BIT_Z'(thrTbl[$urandom_range(0, 2)]);
         st = ($urandom_range(0, 39) == 0) || (!mOpen && ($urandom_range(0, 3) == 0));
         applyStimulus(st, ($urandom_range(0, 3) != 0), zTbl[$urandom_range(0, 11)],
                       int'($urandom_range(0, 2)));
         if ($urandom_range(0, 599) == 0) applyReset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
